// File: rtl/vector_decode_stage.sv
// vector_decode_stage: vector register file, RAW/WAW scoreboard and a registered
// ID/EX stage with valid/ready handshake, flush and sticky finish.
module vector_decode_stage #(
   parameter int LANES   = 8,
   parameter int LANE_W  = 16,
   parameter int NREGS   = 16,
   parameter int VW      = LANES * LANE_W,
   parameter int RW      = $clog2(NREGS),
   parameter int INSTR_W = 6 + 3 * RW
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               in_valid_i,
   input  logic [INSTR_W-1:0] in_instr_i,
   output logic               in_ready_o,
   input  logic               wb_en_i,
   input  logic [RW-1:0]      wb_addr_i,
   input  logic [VW-1:0]      wb_data_i,
   input  logic               flush_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [VW-1:0]      out_rd1_o,
   output logic [VW-1:0]      out_rd2_o,
   output logic [RW-1:0]      out_rd_o,
   output logic [1:0]         out_alu_op_o,
   output logic               out_reg_write_o,
   output logic               out_mem_read_o,
   output logic               out_mem_write_o,
   output logic               out_branch_o,
   output logic               illegal_o,
   output logic               finish_o
);
   logic [VW-1:0] rf_q [NREGS];
   logic [1:0]    cnt_q [NREGS];
   logic [1:0]    cnt_d [NREGS];
   logic [1:0]    dec [NREGS];
   logic [5:0]    op;
   logic [RW-1:0] rd, rs1, rs2;
   logic          known, rw, use1, use2, mr, mw, br, halt, stall, fire, accept;
   logic [1:0]    alu;
   logic [VW-1:0] rd1, rd2;
   logic          out_valid_q, reg_write_q, mem_read_q, mem_write_q, branch_q, halt_q;
   logic          illegal_q, finish_q;
   logic [VW-1:0] rd1_q, rd2_q;
   logic [RW-1:0] rd_q;
   logic [1:0]    alu_q;

   assign op    = in_instr_i[INSTR_W-1 -: 6];
   assign rd    = in_instr_i[3*RW-1 -: RW];
   assign rs1   = in_instr_i[2*RW-1 -: RW];
   assign rs2   = in_instr_i[RW-1:0];
   assign known = op <= 6'h06 || op == 6'h3f;
   assign rw    = op >= 6'h01 && op <= 6'h04;
   assign use1  = op >= 6'h01 && op <= 6'h06;
   assign use2  = (op >= 6'h01 && op <= 6'h03) || op == 6'h05;
   assign mr    = op == 6'h04;
   assign mw    = op == 6'h05;
   assign br    = op == 6'h06;
   assign halt  = op == 6'h3f;
   assign alu   = op == 6'h01 ? 2'd0 : op == 6'h02 ? 2'd1 : op == 6'h03 ? 2'd2 : 2'd3;

   // A register is busy only if it stays pending after this cycle's write-back.
   function automatic logic busy(input logic [RW-1:0] r);
      return r != '0 && cnt_q[r] > 2'(wb_en_i && wb_addr_i == r);
   endfunction

   assign rd1        = rs1 == '0 ? '0 : (wb_en_i && wb_addr_i == rs1) ? wb_data_i : rf_q[rs1];
   assign rd2        = rs2 == '0 ? '0 : (wb_en_i && wb_addr_i == rs2) ? wb_data_i : rf_q[rs2];
   assign stall      = in_valid_i & ((use1 & busy(rs1)) | (use2 & busy(rs2)) | (rw & busy(rd)));
   assign fire       = out_valid_q & out_ready_i & ~flush_i;
   assign in_ready_o = rst_ni & ~stall & ~flush_i & ~finish_q & (~out_valid_q | fire);
   assign accept     = in_valid_i & in_ready_o;

   // Write-back and a flushed writer both retire one outstanding write; a new writer adds one.
   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
         dec[i]   = 2'(wb_en_i && wb_addr_i == RW'(i))
                  + 2'(flush_i && out_valid_q && reg_write_q && rd_q == RW'(i));
         cnt_d[i] = (cnt_q[i] > dec[i] ? cnt_q[i] - dec[i] : 2'd0)
                  + 2'(accept && rw && rd != '0 && rd == RW'(i));
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NREGS; i++) begin
            rf_q[i]  <= '0;
            cnt_q[i] <= '0;
         end
         out_valid_q <= 1'b0;
         rd1_q       <= '0;
         rd2_q       <= '0;
         rd_q        <= '0;
         alu_q       <= '0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         branch_q    <= 1'b0;
         halt_q      <= 1'b0;
         illegal_q   <= 1'b0;
         finish_q    <= 1'b0;
      end else begin
         for (int i = 0; i < NREGS; i++) cnt_q[i] <= cnt_d[i];
         if (wb_en_i && wb_addr_i != '0) rf_q[wb_addr_i] <= wb_data_i;
         illegal_q <= accept & ~known;
         if (fire && halt_q) finish_q <= 1'b1;
         if (accept) begin
            out_valid_q <= 1'b1;
            rd1_q       <= rd1;
            rd2_q       <= rd2;
            rd_q        <= rd;
            alu_q       <= alu;
            reg_write_q <= rw;
            mem_read_q  <= mr;
            mem_write_q <= mw;
            branch_q    <= br;
            halt_q      <= halt;
         end else if (fire || flush_i) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid_o     = out_valid_q;
   assign out_rd1_o       = rd1_q;
   assign out_rd2_o       = rd2_q;
   assign out_rd_o        = rd_q;
   assign out_alu_op_o    = alu_q;
   assign out_reg_write_o = reg_write_q;
   assign out_mem_read_o  = mem_read_q;
   assign out_mem_write_o = mem_write_q;
   assign out_branch_o    = branch_q;
   assign illegal_o       = illegal_q;
   assign finish_o        = finish_q;
endmodule

// File: tb/tb_vector_decode_stage.sv
// tb_vector_decode_stage: directed scenarios plus randomized traffic checked
// against a per-register outstanding-write count model.
module tb_vector_decode_stage;
   localparam int LANES = 8, LANE_W = 16, NREGS = 16, RW = 4, VW = 128, IW = 18;
   localparam int OW = 1 + 2*VW + RW + 2 + 6;

   logic clk = 1'b0, rst_n = 1'b0;
   logic in_valid, in_ready, wb_en, flush, out_valid, out_ready;
   logic [IW-1:0] in_instr;
   logic [RW-1:0] wb_addr, out_rd;
   logic [VW-1:0] wb_data, out_rd1, out_rd2;
   logic [1:0] out_alu_op;
   logic out_reg_write, out_mem_read, out_mem_write, out_branch, illegal, finish;
   int total = 0, bad = 0;

   logic [VW-1:0] rf_m [NREGS];
   int pc_m [NREGS];
   logic ev, e_rw, e_mr, e_mw, e_br, e_halt, e_ill, e_fin;
   logic [VW-1:0] e_rd1, e_rd2;
   logic [RW-1:0] e_rd;
   logic [1:0] e_alu;

   always #5 clk = ~clk;

   vector_decode_stage dut (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_instr_i(in_instr),
      .in_ready_o(in_ready), .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
      .flush_i(flush), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_rd1_o(out_rd1), .out_rd2_o(out_rd2), .out_rd_o(out_rd), .out_alu_op_o(out_alu_op),
      .out_reg_write_o(out_reg_write), .out_mem_read_o(out_mem_read),
      .out_mem_write_o(out_mem_write), .out_branch_o(out_branch),
      .illegal_o(illegal), .finish_o(finish)
   );

   function automatic logic [IW-1:0] mk(input int op, input int rd, input int a, input int b);
      return {op[5:0], rd[RW-1:0], a[RW-1:0], b[RW-1:0]};
   endfunction

   function automatic logic is_known(input int op); return op <= 6 || op == 63; endfunction
   function automatic logic writes(input int op);   return op >= 1 && op <= 4; endfunction
   function automatic logic reads1(input int op);   return op >= 1 && op <= 6; endfunction
   function automatic logic reads2(input int op);   return (op >= 1 && op <= 3) || op == 5; endfunction

   function automatic int left_after_wb(input int r);
      if (r == 0) return 0;
      return pc_m[r] - ((wb_en && int'(wb_addr) == r) ? 1 : 0);
   endfunction

   function automatic logic [VW-1:0] rdv(input int r);
      if (r == 0) return '0;
      if (wb_en && int'(wb_addr) == r) return wb_data;
      return rf_m[r];
   endfunction

   function automatic logic m_ready();
      int op = int'(in_instr[IW-1 -: 6]);
      int rd = int'(in_instr[3*RW-1 -: RW]);
      int a  = int'(in_instr[2*RW-1 -: RW]);
      int b  = int'(in_instr[RW-1:0]);
      logic st = in_valid && ((reads1(op) && left_after_wb(a) > 0) ||
                              (reads2(op) && left_after_wb(b) > 0) ||
                              (writes(op) && left_after_wb(rd) > 0));
      logic fire = ev && out_ready && !flush;
      return rst_n && !flush && !e_fin && (!ev || fire) && !st;
   endfunction

   function automatic void m_reset();
      for (int i = 0; i < NREGS; i++) begin rf_m[i] = '0; pc_m[i] = 0; end
      {ev, e_rw, e_mr, e_mw, e_br, e_halt, e_ill, e_fin} = '0;
      e_rd1 = '0; e_rd2 = '0; e_rd = '0; e_alu = '0;
   endfunction

   function automatic void m_tick();
      int op = int'(in_instr[IW-1 -: 6]);
      int rd = int'(in_instr[3*RW-1 -: RW]);
      int a  = int'(in_instr[2*RW-1 -: RW]);
      int b  = int'(in_instr[RW-1:0]);
      logic acc = in_valid && m_ready();
      logic fire = ev && out_ready && !flush;
      if (wb_en && wb_addr != 0 && pc_m[wb_addr] > 0) pc_m[wb_addr]--;
      if (flush && ev && e_rw && e_rd != 0 && pc_m[e_rd] > 0) pc_m[e_rd]--;
      if (acc && writes(op) && rd != 0) pc_m[rd]++;
      e_ill = acc && !is_known(op);
      if (fire && e_halt) e_fin = 1'b1;
      if (acc) begin
         ev = 1'b1; e_rd1 = rdv(a); e_rd2 = rdv(b); e_rd = RW'(rd);
         e_alu = op == 1 ? 2'd0 : op == 2 ? 2'd1 : op == 3 ? 2'd2 : 2'd3;
         e_rw = writes(op); e_mr = op == 4; e_mw = op == 5; e_br = op == 6; e_halt = op == 63;
      end else if (fire || flush) ev = 1'b0;
      if (wb_en && wb_addr != 0) rf_m[wb_addr] = wb_data;
   endfunction

   task automatic step();
      @(posedge clk);
      m_tick();
      #1;
   endtask

   task automatic idle();
      in_valid = 0; in_instr = '0; wb_en = 0; wb_addr = '0; wb_data = '0; flush = 0; out_ready = 1;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 0;
      m_reset();
      #3;
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_reset();
      idle();
      in_valid = 1; in_instr = mk(1, 1, 2, 3);
      rst_n = 0;
      m_reset();
      #1;
      total++;
      if ({out_valid, out_rd1, out_rd2, out_rd, out_alu_op, out_reg_write, illegal, finish, in_ready} !== '0) begin
         bad++; $display("FAIL reset_outputs: got valid=%b rd=%0d fin=%b ill=%b in_ready=%b, want all 0",
                         out_valid, out_rd, finish, illegal, in_ready);
      end
      @(negedge clk);
      rst_n = 1;
      idle();
   endtask

   task automatic test_basic();
      logic [VW-1:0] ones = {LANES{16'h0001}};
      do_reset();
      wb_en = 1; wb_addr = 3; wb_data = ones;
      step();
      wb_en = 0; in_valid = 1; in_instr = mk(1, 4, 3, 0);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready: got %b want 1", in_ready); end
      step();
      in_valid = 0;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", out_valid); end
      total++; if (out_rd1 !== ones) begin bad++; $display("FAIL basic_rd1: got %h want %h", out_rd1, ones); end
      total++; if (out_rd2 !== '0) begin bad++; $display("FAIL basic_rd2: got %h want 0", out_rd2); end
      total++; if ({out_alu_op, out_reg_write, out_rd} !== {2'd0, 1'b1, 4'd4}) begin
         bad++; $display("FAIL basic_ctrl: got alu=%0d rw=%b rd=%0d want alu=0 rw=1 rd=4", out_alu_op, out_reg_write, out_rd);
      end
   endtask

   task automatic test_raw();
      logic [VW-1:0] d = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_valid = 1; in_instr = mk(1, 5, 3, 3);
      step();
      in_instr = mk(2, 7, 5, 0);
      for (int k = 0; k < 3; k++) begin
         #1;
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL raw_stall%0d: got in_ready=%b want 0", k, in_ready); end
         step();
      end
      wb_en = 1; wb_addr = 5; wb_data = d;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL raw_release: got in_ready=%b want 1", in_ready); end
      step();
      wb_en = 0; in_valid = 0;
      total++; if (out_rd1 !== d || out_alu_op !== 2'd1 || out_rd !== 4'd7) begin
         bad++; $display("FAIL raw_bypass: got rd1=%h alu=%0d rd=%0d want rd1=%h alu=1 rd=7", out_rd1, out_alu_op, out_rd, d);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      out_ready = 0; in_valid = 1; in_instr = mk(1, 1, 2, 3);
      step();
      in_instr = mk(2, 2, 3, 4);
      for (int k = 0; k < 4; k++) begin
         #1;
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready%0d: got %b want 0", k, in_ready); end
         step();
         total++; if ({out_valid, out_rd, out_alu_op} !== {1'b1, 4'd1, 2'd0}) begin
            bad++; $display("FAIL bp_hold%0d: got v=%b rd=%0d alu=%0d want v=1 rd=1 alu=0", k, out_valid, out_rd, out_alu_op);
         end
      end
      out_ready = 1;
      for (int k = 0; k < 5; k++) begin
         in_instr = mk(3, 8 + k, 3, 4);
         #1;
         total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d: got %b want 1", k, in_ready); end
         step();
         total++; if ({out_valid, out_rd, out_alu_op} !== {1'b1, 4'(8 + k), 2'd2}) begin
            bad++; $display("FAIL b2b_out%0d: got v=%b rd=%0d alu=%0d want v=1 rd=%0d alu=2", k, out_valid, out_rd, out_alu_op, 8 + k);
         end
      end
      in_valid = 0;
   endtask

   task automatic test_flush();
      do_reset();
      in_valid = 1; in_instr = mk(4, 6, 2, 0);
      step();
      total++; if ({out_valid, out_mem_read, out_reg_write} !== 3'b111) begin
         bad++; $display("FAIL flush_vld: got v=%b mr=%b rw=%b want 1 1 1", out_valid, out_mem_read, out_reg_write);
      end
      flush = 1; in_instr = mk(1, 7, 6, 0);
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_block: got in_ready=%b want 0", in_ready); end
      step();
      flush = 0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_kill: got out_valid=%b want 0", out_valid); end
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_pending: got in_ready=%b want 1", in_ready); end
      step();
      in_valid = 0;
      total++; if ({out_valid, out_rd} !== {1'b1, 4'd7}) begin
         bad++; $display("FAIL flush_issue: got v=%b rd=%0d want v=1 rd=7", out_valid, out_rd);
      end
   endtask

   task automatic test_illegal_halt();
      do_reset();
      in_valid = 1; in_instr = mk(6'h2A, 3, 1, 2);
      step();
      in_valid = 0;
      total++; if ({illegal, out_reg_write, out_valid} !== 3'b101) begin
         bad++; $display("FAIL illegal_pulse: got ill=%b rw=%b v=%b want 1 0 1", illegal, out_reg_write, out_valid);
      end
      step();
      total++; if (illegal !== 1'b0) begin bad++; $display("FAIL illegal_once: got %b want 0", illegal); end
      in_valid = 1; in_instr = mk(63, 0, 0, 0);
      step();
      in_valid = 0;
      total++; if ({out_valid, finish} !== 2'b10) begin bad++; $display("FAIL halt_in: got v=%b fin=%b want 1 0", out_valid, finish); end
      step();
      total++; if (finish !== 1'b1) begin bad++; $display("FAIL halt_finish: got %b want 1", finish); end
      in_valid = 1; in_instr = mk(1, 1, 2, 3);
      for (int k = 0; k < 3; k++) begin
         #1;
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL halt_block%0d: got in_ready=%b want 0", k, in_ready); end
         step();
         total++; if ({finish, out_valid} !== 2'b10) begin bad++; $display("FAIL halt_sticky%0d: got fin=%b v=%b want 1 0", k, finish, out_valid); end
      end
      in_valid = 0;
   endtask

   task automatic test_r0();
      do_reset();
      wb_en = 1; wb_addr = 0; wb_data = '1; in_valid = 1; in_instr = mk(1, 1, 0, 0);
      step();
      wb_en = 0;
      total++; if ({out_rd1, out_rd2} !== '0) begin bad++; $display("FAIL r0_bypass: got %h %h want 0", out_rd1, out_rd2); end
      in_instr = mk(1, 2, 0, 0);
      step();
      in_valid = 0;
      total++; if ({out_valid, out_rd1} !== {1'b1, {VW{1'b0}}}) begin
         bad++; $display("FAIL r0_read: got v=%b rd1=%h want v=1 rd1=0", out_valid, out_rd1);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      in_valid = 1; in_instr = mk(1, 5, 1, 1);
      step();
      in_instr = mk(1, 6, 5, 0);
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_stall: got in_ready=%b want 0", in_ready); end
      rst_n = 0;
      m_reset();
      #1;
      total++; if ({out_valid, out_rd1, out_rd, out_reg_write, in_ready} !== '0) begin
         bad++; $display("FAIL mid_reset: got v=%b rd=%0d rw=%b in_ready=%b want 0", out_valid, out_rd, out_reg_write, in_ready);
      end
      @(negedge clk);
      rst_n = 1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_release: got in_ready=%b want 1", in_ready); end
      step();
      in_valid = 0;
      total++; if ({out_valid, out_rd} !== {1'b1, 4'd6}) begin bad++; $display("FAIL mid_issue: got v=%b rd=%0d want 1 6", out_valid, out_rd); end
   endtask

   task automatic test_random();
      int ops [9] = '{0, 1, 2, 3, 4, 5, 6, 42, 16};
      logic [OW-1:0] got, exp;
      do_reset();
      for (int c = 0; c < 500; c++) begin
         in_valid  = $urandom_range(0, 3) != 0;
         in_instr  = mk(ops[$urandom_range(0, 8)], $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
         wb_en     = $urandom_range(0, 2) == 0;
         wb_addr   = RW'($urandom_range(0, 7));
         wb_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
         flush     = $urandom_range(0, 9) == 0;
         out_ready = $urandom_range(0, 3) != 0;
         #1;
         total++; if (in_ready !== m_ready()) begin bad++; $display("FAIL rand_ready@%0d: got %b want %b", c, in_ready, m_ready()); end
         step();
         got = {out_valid, out_rd1, out_rd2, out_rd, out_alu_op, out_reg_write, out_mem_read, out_mem_write, out_branch, illegal, finish};
         exp = {ev, e_rd1, e_rd2, e_rd, e_alu, e_rw, e_mr, e_mw, e_br, e_ill, e_fin};
         total++; if (got !== exp) begin bad++; $display("FAIL rand_out@%0d: got %h want %h", c, got, exp); end
      end
      idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_basic();
      test_raw();
      test_back_to_back();
      test_flush();
      test_illegal_halt();
      test_r0();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/vector_decode_stage.md
Name: vector_decode_stage

Overview:
- Parametrised decode stage for the vector pipeline; successor to the fixed 128-bit / 16-register decode.
- Contains a LANES x LANE_W vector register file with write-back port and a per-register scoreboard (RAW/WAW stall).
- Has a registered ID/EX output stage with valid/ready handshake on both sides, plus flush and sticky finish.
- Sits between fetch and execute; write-back enters from the WB stage.

Parameters:
- LANES, 8, vector lanes per register.
- LANE_W, 16, bits per lane; VW = LANES*LANE_W.
- NREGS, 16, vector registers (power of two, >=4); RW = log2(NREGS).
- INSTR_W, 6+3*RW, instruction width; fields [INSTR_W-1 -: 6] opcode, rd, rs1, rs2 in descending order.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents instruction.
- in_instr  in  INSTR_W  instruction word.
- in_ready  out  1  stage accepts in_instr this cycle.
- wb_en  in  1  write-back strobe.
- wb_addr  in  RW  write-back register.
- wb_data  in  VW  write-back data.
- flush  in  1  kill the ID/EX contents (branch taken in execute).
- out_valid  out  1  ID/EX register holds an instruction.
- out_ready  in  1  execute consumes it.
- out_rd1, out_rd2  out  VW  operand vectors.
- out_rd  out  RW  destination register.
- out_alu_op  out  2  0=add, 1=sub, 2=mul, 3=pass.
- out_reg_write, out_mem_read, out_mem_write, out_branch  out  1  control bits.
- illegal  out  1  one-cycle pulse on acceptance of an undefined opcode.
- finish  out  1  sticky halt indication.

Behaviour:
- Reset (async assert, sync release): all registers, scoreboard, out_* and out_valid = 0; finish = 0; illegal = 0; in_ready = 0 while reset is asserted.
- Opcodes:
  - 00 NOP: no control bits.
  - 01/02/03 VADD/VSUB/VMUL: reg_write; alu_op 0/1/2.
  - 04 VLD: mem_read, reg_write; rs1 = address.
  - 05 VST: mem_write; rs1 = address, rs2 = data.
  - 06 BEQZ: branch; reads rs1.
  - 3F HALT: no control bits.
  - Any other opcode: decoded as NOP and pulses illegal.
- Register 0: reads 0, writes dropped, never pending.
- Read ports: combinational from the register file. If wb_en and wb_addr == rs (nonzero) in the same cycle, wb_data is bypassed to the read port.
- Scoreboard:
  - Pending bit sets when a reg_write instruction is accepted into ID/EX.
  - Pending bit clears on wb_en for that register.
  - If set and clear hit the same register in the same cycle, set wins.
- Hazard: stall = in_valid AND any used source or rd (if reg_write) has pending=1 and is not cleared by this cycle's wb. Unused fields are ignored.
- Handshake:
  - fire_out = out_valid & out_ready & ~flush.
  - in_ready = ~stall & ~flush & ~finish & (~out_valid | fire_out).
  - Accept = in_valid & in_ready; operands and controls are registered into ID/EX; latency 1 cycle.
  - Without accept: fire_out clears out_valid; otherwise ID/EX holds stable.
- Flush:
  - out_valid <- 0 next cycle; no accept that cycle.
  - If the killed instruction had reg_write, its pending bit is cleared, unless an older write to the same register is still outstanding. Track this with a 2-bit pending counter per register; saturation at 3 forces a stall.
- Finish: set when a HALT fires out of ID/EX. Once set, no further accepts; cleared only by reset.
- Reset mid-operation discards the ID/EX contents and all pending state.

Test Plan:
- Reset then write-back v3 = 0x0001 per lane; VADD rd=4, rs1=3, rs2=0 -> next cycle out_valid=1, out_rd1 lanes = 0x0001, out_rd2 = 0, out_alu_op=0, out_reg_write=1.
- VADD rd=5; then VSUB rs1=5 -> VSUB held (in_ready=0) until wb_en, wb_addr=5; accepted that same cycle with wb_data bypassed.
- out_ready=0 for 4 cycles with in_valid=1 -> out_* stable, in_ready=0; on out_ready=1, back-to-back independent instructions fire every cycle.
- VLD rd=6 in ID/EX plus flush -> out_valid=0 next cycle, pending[6]=0; VADD rs1=6 then issues without stall.
- Opcode 0x2A -> illegal pulses one cycle, out_reg_write=0. HALT fires -> finish=1 and stays 1; in_ready=0 thereafter.
- Write wb_addr=0 with 0xFFFF, then read r0 -> 0. Assert reset mid-stall -> all outputs 0 immediately.
